// File: rtl/adc_tx_if.sv
// Input word stream for adc_tx: valid/ready handshake carrying one packed
// channel A / channel B sample pair per word.
interface adc_tx_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/adc_tx.sv
// Two-lane-per-channel serial ADC sample transmitter.
// Each 7-slot frame carries one 14-bit channel A and one 14-bit channel B
// sample, MSB first, two bits per lane pair per slot, with a 1111000 frame
// sync lane. Words arrive through a one-entry holding register; if it is
// empty at a frame load, the previous word is repeated and an underrun is
// flagged.
// Optional build macro ADC_TX_RAMP_EN adds a ramp_mode input that replaces
// the loaded word with an internal 14-bit test ramp (A=cnt, B=~cnt).
//
// state | meaning
// IDLE  | lanes held at 0, waiting for tx_en
// RUN   | transmitting frames; slot counts 0..6
module adc_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_en,
`ifdef ADC_TX_RAMP_EN
    input  logic        ramp_mode,
`endif
    adc_tx_if.slave     s_in,
    output logic [1:0]  cha,
    output logic [1:0]  chb,
    output logic        frame,
    output logic        frame_start,
    output logic        busy,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [2:0]  slot;
    logic        load;
    logic        accept;
    logic        ramp_act;
    logic        hold_full, hold_full_nxt;
    logic [13:0] hold_a, hold_b;
    logic [13:0] sh_a, sh_b;
    logic [13:0] last_a, last_b;
    logic [13:0] ld_a, ld_b;
    logic        ld_under;
    logic        unused_bits;

    assign unused_bits = ^{s_in.in_data[31:30], s_in.in_data[15:14]};
    assign accept      = s_in.in_valid & s_in.in_ready;
    assign busy        = (state == RUN);

`ifdef ADC_TX_RAMP_EN
    logic [13:0] ramp_cnt;
    assign ramp_act = ramp_mode;
`else
    assign ramp_act = 1'b0;
`endif

    // Next state and frame-load decision; loads happen on RUN entry and on each frame wrap.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (tx_en) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                if (slot == 3'd6) begin
                    if (tx_en) load      = 1'b1;
                    else       state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Select the word to load: test ramp, held word, or a repeat of the last word.
    always_comb begin
        ld_a     = last_a;
        ld_b     = last_b;
        ld_under = 1'b1;
        if (hold_full) begin
            ld_a     = hold_a;
            ld_b     = hold_b;
            ld_under = 1'b0;
        end
`ifdef ADC_TX_RAMP_EN
        if (ramp_mode) begin
            ld_a     = ramp_cnt;
            ld_b     = ~ramp_cnt;
            ld_under = 1'b0;
        end
`endif
        hold_full_nxt = accept | (hold_full & ~(load & ~ramp_act));
    end

    // State register and slot counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            slot  <= 3'd0;
        end else begin
            state <= state_nxt;
            slot  <= (state_nxt == RUN && !load) ? slot + 3'd1 : 3'd0;
        end
    end

    // Holding register; a load frees it in the same edge, ready follows one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full     <= 1'b0;
            hold_a        <= 14'd0;
            hold_b        <= 14'd0;
            s_in.in_ready <= 1'b0;
        end else begin
            hold_full     <= hold_full_nxt;
            s_in.in_ready <= ~hold_full_nxt & ~ramp_act;
            if (accept) begin
                hold_a <= s_in.in_data[13:0];
                hold_b <= s_in.in_data[29:16];
            end
        end
    end

    // Shift registers and registered lane outputs; the load edge drives slot 0 directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_a           <= 14'd0;
            sh_b           <= 14'd0;
            last_a         <= 14'd0;
            last_b         <= 14'd0;
            cha            <= 2'b00;
            chb            <= 2'b00;
            frame          <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= 16'd0;
        end else if (load) begin
            sh_a        <= {ld_a[11:0], 2'b00};
            sh_b        <= {ld_b[11:0], 2'b00};
            last_a      <= ld_a;
            last_b      <= ld_b;
            cha         <= ld_a[13:12];
            chb         <= ld_b[13:12];
            frame       <= 1'b1;
            frame_start <= 1'b1;
            underrun    <= ld_under;
            if (ld_under && underrun_count != 16'hFFFF)
                underrun_count <= underrun_count + 16'd1;
        end else if (state_nxt == RUN) begin
            sh_a        <= {sh_a[11:0], 2'b00};
            sh_b        <= {sh_b[11:0], 2'b00};
            cha         <= sh_a[13:12];
            chb         <= sh_b[13:12];
            frame       <= (slot < 3'd3);
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            cha         <= 2'b00;
            chb         <= 2'b00;
            frame       <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end
    end

`ifdef ADC_TX_RAMP_EN
    // Test ramp advances once per frame loaded in ramp mode, wrapping naturally at 0x3FFF.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ramp_cnt <= 14'd0;
        else if (load && ramp_mode)
            ramp_cnt <= ramp_cnt + 14'd1;
    end
`endif

endmodule

// File: tb/tb_adc_tx.sv
// Self-checking bench for adc_tx (default build, ramp feature disabled).
// A frame-level reference model predicts every output each cycle.
module tb_adc_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_en = 1'b0;
    logic [1:0]  cha, chb;
    logic        frame, frame_start, busy, underrun;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    adc_tx_if u_if ();

    adc_tx dut (
        .clk            (clk),
        .reset          (reset),
        .tx_en          (tx_en),
        .s_in           (u_if),
        .cha            (cha),
        .chb            (chb),
        .frame          (frame),
        .frame_start    (frame_start),
        .busy           (busy),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    // reference model: frame position, word on air, holding slot, counters
    bit          m_run;
    int          m_pos;
    int unsigned m_a, m_b, m_last_a, m_last_b, m_ha, m_hb;
    bit          m_hfull, m_ready, m_ur;
    int unsigned m_cnt;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_a = 0; m_b = 0; m_last_a = 0; m_last_b = 0;
        m_ha = 0; m_hb = 0; m_hfull = 0; m_ready = 0; m_ur = 0; m_cnt = 0;
    endtask

    task automatic model_start_frame();
        m_run = 1;
        m_pos = 0;
        if (m_hfull) begin
            m_a = m_ha; m_b = m_hb; m_hfull = 0; m_ur = 0;
        end else begin
            m_a = m_last_a; m_b = m_last_b; m_ur = 1;
            if (m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        end
        m_last_a = m_a;
        m_last_b = m_b;
    endtask

    task automatic model_edge(input bit tx, input bit v, input logic [31:0] d);
        bit acc;
        acc = v && m_ready;
        if (!m_run) begin
            if (tx) model_start_frame();
        end else if (m_pos == 6) begin
            if (tx) model_start_frame();
            else    begin m_run = 0; m_pos = 0; end
        end else begin
            m_pos = m_pos + 1;
        end
        if (acc) begin
            m_ha = d[13:0];
            m_hb = d[29:16];
            m_hfull = 1;
        end
        m_ready = !m_hfull;
    endtask

    task automatic check_all(input string tag);
        logic [1:0]  e_cha, e_chb;
        logic        e_frame, e_fs, e_busy, e_ur, e_rdy;
        logic [15:0] e_cnt;
        e_cha   = m_run ? 2'((m_a >> (12 - 2 * m_pos)) & 3) : 2'b00;
        e_chb   = m_run ? 2'((m_b >> (12 - 2 * m_pos)) & 3) : 2'b00;
        e_frame = m_run && (m_pos < 4);
        e_fs    = m_run && (m_pos == 0);
        e_busy  = m_run;
        e_ur    = m_run && (m_pos == 0) && m_ur;
        e_rdy   = m_ready;
        e_cnt   = 16'(m_cnt);
        checks++; assert (cha === e_cha) else begin errors++; $error("FAIL %s cha got %b exp %b", tag, cha, e_cha); end
        checks++; assert (chb === e_chb) else begin errors++; $error("FAIL %s chb got %b exp %b", tag, chb, e_chb); end
        checks++; assert (frame === e_frame) else begin errors++; $error("FAIL %s frame got %b exp %b", tag, frame, e_frame); end
        checks++; assert (frame_start === e_fs) else begin errors++; $error("FAIL %s frame_start got %b exp %b", tag, frame_start, e_fs); end
        checks++; assert (busy === e_busy) else begin errors++; $error("FAIL %s busy got %b exp %b", tag, busy, e_busy); end
        checks++; assert (underrun === e_ur) else begin errors++; $error("FAIL %s underrun got %b exp %b", tag, underrun, e_ur); end
        checks++; assert (underrun_count === e_cnt) else begin errors++; $error("FAIL %s underrun_count got %h exp %h", tag, underrun_count, e_cnt); end
        checks++; assert (u_if.in_ready === e_rdy) else begin errors++; $error("FAIL %s in_ready got %b exp %b", tag, u_if.in_ready, e_rdy); end
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(input bit tx, input bit v, input logic [31:0] d, input string tag);
        tx_en = tx;
        u_if.in_valid = v;
        u_if.in_data = d;
        @(posedge clk);
        model_edge(tx, v, d);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic reset_dut(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_data = 32'd0;
        @(negedge clk);
        reset_dut("reset");
        cyc(0, 0, 0, "idle_ready");

        // single word 0x2AAA: cha[1] all ones, cha[0] all zeros, pattern 1111000
        cyc(0, 1, 32'h0000_2AAA, "accept_idle");
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, "word_2aaa");
        checks++; assert (underrun_count === 16'd0) else begin errors++; $error("FAIL cnt_after_2aaa got %h exp 0000", underrun_count); end

        // back-to-back words, no gap
        reset_dut("reset2");
        cyc(0, 0, 0, "idle2");
        cyc(0, 1, 32'h3FFF_0000, "b2b_first");
        cyc(1, 1, 32'h0000_3FFF, "b2b_load");
        cyc(1, 1, 32'h0000_3FFF, "b2b_accept");
        for (int i = 0; i < 12; i++) cyc(1, 0, 0, "b2b_run");
        checks++; assert (underrun_count === 16'd0) else begin errors++; $error("FAIL b2b_no_underrun got %h exp 0000", underrun_count); end

        // starvation: repeated word, one underrun per frame
        for (int i = 0; i < 21; i++) cyc(1, 0, 0, "starve");
        checks++; assert (underrun_count === 16'd3) else begin errors++; $error("FAIL starve_count got %h exp 0003", underrun_count); end

        // saturation near the top of the counter
        force dut.underrun_count = 16'hFFFE;
        #1;
        release dut.underrun_count;
        m_cnt = 32'hFFFE;
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, "saturate");
        checks++; assert (underrun_count === 16'hFFFF) else begin errors++; $error("FAIL saturate_hold got %h exp ffff", underrun_count); end

        // drop tx_en in slot 2: frame completes, then IDLE, then restart
        for (int i = 0; i < 10 && !(m_run && m_pos == 1); i++) cyc(1, 0, 0, "seek_slot1");
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, "drain");
        checks++; assert (busy === 1'b0) else begin errors++; $error("FAIL drain_idle got busy=%b exp 0", busy); end
        cyc(1, 0, 0, "restart");
        checks++; assert (frame_start === 1'b1) else begin errors++; $error("FAIL restart_fs got %b exp 1", frame_start); end

        // reset at slot 4 with the holding register full
        cyc(1, 1, 32'h1234_0567, "fill_hold");
        for (int i = 0; i < 10 && !(m_run && m_pos == 4); i++) cyc(1, 0, 0, "seek_slot4");
        reset_dut("reset_mid");
        cyc(0, 0, 0, "post_reset");
        checks++; assert (u_if.in_ready === 1'b1) else begin errors++; $error("FAIL post_reset_ready got %b exp 1", u_if.in_ready); end
        cyc(1, 0, 0, "post_reset_run");

        // randomized traffic
        for (int i = 0; i < 600; i++)
            cyc(($urandom % 8) != 0, $urandom % 2, $urandom, "random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_tx.md
ADC_TX -- requirements
Module: adc_tx

Interface
REQ-001 clk  input  1  bit-rate clock; one serial bit per lane per rising edge; also used as the forwarded bit clock.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 tx_en  input  1  enables transmission; sampled every cycle.
REQ-004 in_valid  input  1  data word valid.
REQ-005 in_data  input  32  bits [13:0] are channel A sample, bits [29:16] are channel B sample, bits [15:14] and [31:30] are ignored.
REQ-006 in_ready  output  1  holding register empty; word accepted when in_valid & in_ready.
REQ-007 cha  output  2  channel A serial lanes.
REQ-008 chb  output  2  channel B serial lanes.
REQ-009 frame  output  1  frame sync lane.
REQ-010 frame_start  output  1  one-cycle pulse coincident with slot 0 of every frame.
REQ-011 busy  output  1  high while the state is RUN.
REQ-012 underrun  output  1  one-cycle pulse when a frame loads with the holding register empty.
REQ-013 underrun_count  output  16  saturating count of underrun pulses.

Function
REQ-014 Frame is 7 bit slots, numbered 0..6; a slot counter SHALL advance by one each RUN cycle and wrap 6->0.
REQ-015 States SHALL be IDLE and RUN only.
REQ-016 IDLE->RUN SHALL occur on the first edge with tx_en=1; the first RUN cycle SHALL be slot 0.
REQ-017 RUN->IDLE SHALL occur only at the edge ending slot 6 with tx_en=0; deasserting tx_en mid-frame SHALL complete the current frame.
REQ-018 In IDLE, cha, chb, frame, frame_start and underrun SHALL be 0.
REQ-019 Lane mapping, MSB first, slot k = 0..6: cha[1] = A[13-2k]; cha[0] = A[12-2k]; chb[1] = B[13-2k]; chb[0] = B[12-2k].
REQ-020 frame SHALL be 1 in slots 0..3 and 0 in slots 4..6, giving pattern 1111000.
REQ-021 All serial outputs SHALL be registered, with no combinational path from inputs.
REQ-022 A one-entry holding register SHALL be used; in_ready = !hold_full, registered.
REQ-023 The shift register SHALL load from the holding register on IDLE->RUN entry and at each slot 6->0 wrap; a load SHALL clear hold_full in the same edge.
REQ-024 An accept in the same cycle as a load SHALL NOT occur, because in_ready was 0 while full; an accept in the cycle after the load SHALL be legal.
REQ-025 Load with hold empty: the shift register SHALL reload the last transmitted word, underrun SHALL pulse during that frame's slot 0, and underrun_count SHALL increment and saturate at 0xFFFF.
REQ-026 Entering RUN with hold empty after reset SHALL transmit all-zero samples and SHALL count as an underrun.
REQ-027 Accepting a word in IDLE SHALL be allowed; the word SHALL wait in hold until RUN entry.
REQ-028 Latency: a word accepted at cycle t while RUN SHALL appear at the next slot 0 after t.

Reset
REQ-029 On reset=0, asynchronously: state=IDLE, slot=0, hold_full=0, in_ready=1 after release, shift register and last-word register=0, all outputs 0, underrun_count=0.
REQ-030 Reset mid-frame SHALL abort immediately, and the held word SHALL be discarded.

Configuration
REQ-031 Macro ADC_TX_RAMP_EN: when defined, an extra input ramp_mode (1 bit) SHALL exist; with ramp_mode=1 the loads SHALL use an internal 14-bit counter (A=cnt, B=~cnt, cnt+1 per frame, wrapping 0x3FFF->0), in_ready SHALL be 0, and no underruns SHALL occur.
REQ-032 When ADC_TX_RAMP_EN is undefined, the port and counter SHALL be absent and the behaviour SHALL be exactly REQ-014..030.

Verification
REQ-033 Reset, write 0x00002AAA (A=0x2AAA, B=0), tx_en=1 -> slot0..6: cha[1]=1111111, cha[0]=0000000, chb=0, frame=1111000, no underrun.
REQ-034 Back-to-back writes 0x3FFF0000, 0x00003FFF with in_valid held high -> second word accepted one cycle after the first frame's load, transmitted in the next frame, no gap, underrun_count=0.
REQ-035 tx_en=1 with no writes -> underrun pulses each frame at slot 0, the last word repeats, and the count reaches 3 after 3 frames; force the count to 0xFFFF -> it stays 0xFFFF.
REQ-036 Drop tx_en at slot 2 -> frame finishes slots 3..6, busy falls after slot 6, lanes are 0 in IDLE; reassert -> slot 0 and frame_start on the first RUN cycle.
REQ-037 Assert reset at slot 4 with hold full -> outputs 0 immediately, in_ready=1 after release, underrun_count=0.
REQ-038 With ADC_TX_RAMP_EN defined and ramp_mode=1 -> consecutive frames carry A=0,1,2 and B=0x3FFF,0x3FFE,0x3FFD; at wrap, 0x3FFF is followed by 0.
